// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
// Digit enables are active-low, so ALL_OFF is the idle level of every enable bit.
package display_pkg;
  localparam int   NIBBLE_W         = 4;
  localparam int   DEF_REFRESH_DIV  = 50000;
  localparam int   DEF_BLANK_CYCLES = 500;
  localparam logic ALL_OFF          = 1'b1;
endpackage

// File: rtl/scan_timer.sv
// Slot/digit timebase for the display scanner. Publishes next-cycle index and
// phase so the top level can register outputs that line up with cnt/idx.
module scan_timer
  import display_pkg::*;
#(
  parameter int  NUM_DIGITS   = 4,
  parameter int  REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int  BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int CNT_W        = $clog2(REFRESH_DIV),
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             slot_end,
  output logic             frame_end,
  output logic             in_blank,
  output logic [IDX_W-1:0] idx_next
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [IDX_W-1:0] r_idx;

  // in_blank describes the cycle that starts at the coming edge.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    slot_end   = (r_cnt == CNT_LAST);
    frame_end  = slot_end && (r_idx == IDX_LAST);
    w_cnt_next = slot_end ? '0 : r_cnt + 1'b1;
    idx_next   = r_idx;
    if (slot_end) idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    in_blank   = (w_cnt_next < CNT_W'(BLANK_CYCLES));
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      r_idx <= idx_next;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode display scanner: frame-synchronous value commit,
// anti-ghost blanking and leading-zero suppression, feeding the hex decoder.
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
  input  logic                           load,
  input  logic                           blank_lead,
  output logic [NIBBLE_W-1:0]            nibble_out,
  output logic [NUM_DIGITS-1:0]          digit_en_n,
  output logic                           frame_tick
);

  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_in_blank;
  logic [IDX_W-1:0]      w_idx_next;

  logic [VAL_W-1:0]      r_shadow;
  logic [VAL_W-1:0]      r_display;
  logic                  r_pending;
  logic [VAL_W-1:0]      w_display_next;
  logic [NUM_DIGITS-1:0] w_lead_zero;
  logic                  w_suppress;
  logic [NIBBLE_W-1:0]   w_nibble_next;
  logic [NUM_DIGITS-1:0] w_en_next;

  logic [NIBBLE_W-1:0]   r_nibble;
  logic [NUM_DIGITS-1:0] r_digit_en_n;
  logic                  r_frame_tick;

  scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_scan_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .slot_end (w_slot_end),
    .frame_end(w_frame_end),
    .in_blank (w_in_blank),
    .idx_next (w_idx_next)
  );

  // A load on the boundary edge bypasses the shadow so it still makes the next frame.
  always_comb begin
    w_display_next = r_display;
    if (w_frame_end) begin
      if (load)           w_display_next = value_in;
      else if (r_pending) w_display_next = r_shadow;
    end
  end

  // w_lead_zero[i]: digits NUM_DIGITS-1 down to i of the upcoming display are all zero.
  always_comb begin
    w_lead_zero = '0;
    w_lead_zero[NUM_DIGITS-1] = (w_display_next[VAL_W-1 -: NIBBLE_W] == '0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_lead_zero[i] = w_lead_zero[i+1] && (w_display_next[i*NIBBLE_W +: NIBBLE_W] == '0);
    end
  end

  always_comb begin
    w_nibble_next = w_display_next[w_idx_next*NIBBLE_W +: NIBBLE_W];
    w_suppress    = blank_lead && (w_idx_next != '0) && w_lead_zero[w_idx_next];
    w_en_next     = {NUM_DIGITS{ALL_OFF}};
    if (!w_in_blank && !w_suppress) w_en_next[w_idx_next] = ~ALL_OFF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow     <= '0;
      r_display    <= '0;
      r_pending    <= 1'b0;
      r_nibble     <= '0;
      r_digit_en_n <= {NUM_DIGITS{ALL_OFF}};
      r_frame_tick <= 1'b0;
    end else begin
      if (load) r_shadow <= value_in;
      r_pending    <= !w_frame_end && (load || r_pending);
      r_display    <= w_display_next;
      // Index and display only move on a slot rollover, so the nibble can too.
      if (w_slot_end) r_nibble <= w_nibble_next;
      r_digit_en_n <= w_en_next;
      r_frame_tick <= w_frame_end;
    end
  end

  assign nibble_out = r_nibble;
  assign digit_en_n = r_digit_en_n;
  assign frame_tick = r_frame_tick;

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexed driver for an NUM_DIGITS-digit common-anode seven-segment display.
- Sits directly upstream of the hex-to-segment decoder. It latches a hex value, steps through the digits, and presents one 4-bit nibble at a time to the decoder.
- Drives the active-low digit enables in step with the nibble.
- Provides anti-ghosting blanking, optional leading-zero suppression, and tear-free updates at frame boundaries.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; must be >= 1.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all digits off; must satisfy 0 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- value_in  in  4*NUM_DIGITS  hex value; bits [3:0] are digit 0 (rightmost).
- load  in  1  single-cycle strobe; captures value_in into the shadow register.
- blank_lead  in  1  enables leading-zero suppression; sampled every cycle.
- nibble_out  out  4  nibble for the decoder input.
- digit_en_n  out  NUM_DIGITS  active-low digit enables; at most one bit is low at any time.
- frame_tick  out  1  one-cycle pulse after the last slot of each frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values while rst_n = 0:
  - Registers: display = 0, shadow = 0, pending = 0, idx = 0, cnt = 0.
  - Outputs: digit_en_n = all ones, nibble_out = 0, frame_tick = 0.
- Reset mid-operation: reset takes effect on the next edge and discards any pending load.
- Counters:
  - cnt counts 0..REFRESH_DIV-1 with width $clog2(REFRESH_DIV).
  - At cnt = REFRESH_DIV-1, cnt wraps to 0 and idx advances by 1, wrapping from NUM_DIGITS-1 to 0.
- Slot phases, derived from cnt:
  - BLANK (cnt < BLANK_CYCLES): digit_en_n = all ones.
  - DRIVE (otherwise): digit_en_n[idx] = 0, all other bits = 1, unless the digit is suppressed.
- Output registration and alignment:
  - Outputs are registered and computed from next-state values, so they align exactly with cnt/idx.
  - The first cycle after rst_n rises is cnt = 0 of digit 0.
- nibble_out:
  - Equals display[4*idx+3 : 4*idx] during both BLANK and DRIVE.
  - This lets the decoder settle before the digit enable asserts.
- Leading-zero suppression:
  - When blank_lead = 1, digit i (i > 0) is suppressed if display digits NUM_DIGITS-1 down to i are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps digit_en_n all ones for its whole slot; nibble_out still shows its value.
- Load and commit:
  - load = 1: shadow <= value_in and pending <= 1. If several loads occur in one frame, the last one wins.
  - The frame boundary is the edge where idx = NUM_DIGITS-1 and cnt = REFRESH_DIV-1.
  - At the frame boundary, if pending = 1: display <= shadow and pending <= 0.
  - load coinciding with the frame boundary: display <= value_in directly, pending <= 0 and shadow <= value_in. The new value is shown from the very next frame.
  - display never changes mid-frame.
- frame_tick: high for exactly one cycle, on the cycle where idx = 0 and cnt = 0, after each frame boundary. It does not pulse on the first cycle after reset.
- Frame period: NUM_DIGITS*REFRESH_DIV cycles.
- Degenerate cases:
  - NUM_DIGITS = 1: every slot end is a frame boundary.
  - BLANK_CYCLES = 0: no blank phase.

Decomposition:
- Shared package, display_pkg, holds:
  - NIBBLE_W = 4.
  - The default REFRESH_DIV and BLANK_CYCLES constants.
  - The active-low enable constant ALL_OFF.
- One sub-module: scan_timer. It owns cnt and idx and outputs slot_end, frame_end and in_blank.
- The top level holds shadow/display/pending, suppression logic and output registers.
- Top-level output nibble_out connects directly to the existing decoder's 4-bit input.

Test Plan:
All scenarios use NUM_DIGITS = 4, REFRESH_DIV = 8, BLANK_CYCLES = 2.
1. Reset: rst_n = 0 for 3 cycles, then release.
   - During reset: digit_en_n = 4'b1111, nibble_out = 0, frame_tick = 0.
   - Post-release cycles 0-1: digit_en_n = 4'b1111.
   - Cycles 2-7: digit_en_n = 4'b1110, nibble_out = 0.
   - frame_tick at cycle 32.
2. Mid-frame load of 16'h1A3F at cycle 10.
   - Cycles 10-31: outputs still show 0.
   - Frame starting at cycle 32: slot nibbles F, 3, A, 1 with enables 1110, 1101, 1011, 0111 in the DRIVE phases.
   - frame_tick pulses every 32 cycles.
3. blank_lead = 1.
   - display 16'h0005: only digit 0 is enabled.
   - display 16'h0000: only digit 0 is enabled, nibble_out = 0.
   - display 16'h0100: digit 3 is suppressed; digits 2, 1 and 0 are driven.
4. load 16'h00C7 on the frame-boundary edge (cycle 31) -> the next frame (from cycle 32) shows 7, C, 0, 0.
5. Two loads in one frame: 16'h1111 at cycle 5, then 16'h2222 at cycle 20 -> the next frame shows only 2222.
6. rst_n = 0 at cycle 44 with a load pending -> reset values apply at cycle 45. After release, display stays 0 through the full next frame.
